// File: rtl/spi_slave_core.sv
// SPI slave core running entirely in the clk_i domain.
// The SPI pins are oversampled, so the SCK half-period must be at least SYNC_STAGES+3 clk.
//   clk_i, rst_n_i            system clock, async active-low reset
//   cpol_i, cpha_i, lsb_i,    SPI mode, bit order and word length (00/01/10/11 = 8/16/24/32);
//   dtb_i                     these are captured when a transaction starts
//   clr_i                     clears the sticky ovr_o/udr_o flags
//   spi_sck_i, spi_cs_n_i,    asynchronous SPI pins
//   spi_mosi_i
//   spi_miso_o, spi_miso_en_o serial data out and its pad enable
//   busy_o                    transaction active
//   tx_valid_i/tx_ready_o/    transmit word handshake; tx_ready_o pulses at each word-load point
//   tx_data_i
//   rx_valid_o/rx_ready_i/    receive word handshake; the word is right-justified
//   rx_data_o
//   ovr_o, udr_o              sticky overrun and underrun flags
module spi_slave_core #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dtb_i,
  input  logic        clr_i,
  input  logic        spi_sck_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o,
  output logic        busy_o,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        ovr_o,
  output logic        udr_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  // Fills with ones after reset. Once the top bit is set, both the synchronized cs_n and the
  // edge flop hold real pin samples. This stops a reset released mid-transaction from
  // looking like a cs_n falling edge.
  logic [SYNC_STAGES:0]   warm_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
    end else begin
      sck_sync_q[0]  <= spi_sck_i;
      cs_sync_q[0]   <= spi_cs_n_i;
      mosi_sync_q[0] <= spi_mosi_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sck_sync_q[i]  <= sck_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
      warm_q[0]  <= 1'b1;
      for (int i = 1; i <= int'(SYNC_STAGES); i++) warm_q[i] <= warm_q[i-1];
    end
  end

  state_e      state_q;
  logic        cpol_q, cpha_q, lsb_q;
  logic [1:0]  dtb_q;
  logic [5:0]  cnt_q;
  logic [31:0] tx_sr_q, rx_sr_q;
  logic        rx_valid_q, ovr_q, udr_q;
  logic [31:0] rx_data_q;

  logic        sck_s, cs_s, mosi_s;
  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic        active, sample_edge, shift_edge, in_word, word_done, entry, load_pt;
  logic [1:0]  ld_dtb;
  logic [5:0]  ld_wlen, wlen;
  logic [31:0] ld_mask, rx_sr_nxt, rx_word;
  logic [4:0]  msb_idx;
  logic        ovr_set, udr_set;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = warm_q[SYNC_STAGES] & cs_prev_q & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev_q;

  assign active      = (state_q == StActive);
  assign sample_edge = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;
  assign shift_edge  = (cpol_q ^ cpha_q) ? sck_rise : sck_fall;
  // cs_n rising takes priority, so a partial word never completes on the deselect cycle.
  assign in_word     = active & ~cs_rise;
  assign word_done   = in_word & sample_edge & (cnt_q == 6'd1);
  assign entry       = ~active & cs_fall;
  assign load_pt     = entry | word_done;

  // On entry the word length comes straight from the input that is being captured.
  assign ld_dtb  = entry ? dtb_i : dtb_q;
  assign ld_wlen = {1'b0, ld_dtb, 3'b000} + 6'd8;
  assign ld_mask = 32'hFFFF_FFFF >> {~ld_dtb, 3'b000};
  assign wlen    = {1'b0, dtb_q, 3'b000} + 6'd8;
  assign msb_idx = {dtb_q, 3'b111};

  // LSB-first words enter at bit 31 and are shifted down when the word completes.
  // MSB-first words already sit right-justified and only need their stale upper bits masked.
  assign rx_sr_nxt = lsb_q ? {mosi_s, rx_sr_q[31:1]} : {rx_sr_q[30:0], mosi_s};
  assign rx_word   = lsb_q ? (rx_sr_nxt >> {~dtb_q, 3'b000})
                           : (rx_sr_nxt & (32'hFFFF_FFFF >> {~dtb_q, 3'b000}));

  assign udr_set = load_pt & ~tx_valid_i;
  assign ovr_set = word_done & rx_valid_q & ~rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      dtb_q      <= 2'b00;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      // A set in the same cycle as clr_i wins.
      ovr_q <= ovr_set | (ovr_q & ~clr_i);
      udr_q <= udr_set | (udr_q & ~clr_i);

      // A completing word can replace the held word only if that word is accepted in this cycle.
      if (word_done && (!rx_valid_q || rx_ready_i)) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_word;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      if (load_pt) begin
        tx_sr_q <= tx_valid_i ? (tx_data_i & ld_mask) : '0;
      end else if (in_word && shift_edge && (cnt_q < wlen)) begin
        tx_sr_q <= lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q <= StActive;
            cpol_q  <= cpol_i;
            cpha_q  <= cpha_i;
            lsb_q   <= lsb_i;
            dtb_q   <= dtb_i;
            cnt_q   <= ld_wlen;
            rx_sr_q <= '0;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (sample_edge) begin
            rx_sr_q <= rx_sr_nxt;
            cnt_q   <= word_done ? ld_wlen : (cnt_q - 6'd1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_miso_o    = active & (lsb_q ? tx_sr_q[0] : tx_sr_q[msb_idx]);
  assign spi_miso_en_o = active;
  assign busy_o        = active;
  assign tx_ready_o    = load_pt;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign ovr_o         = ovr_q;
  assign udr_o         = udr_q;

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;

  localparam int HALF = 8;  // SCK half-period in clk cycles

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cpol_i, cpha_i, lsb_i, clr_i;
  logic [1:0]  dtb_i;
  logic        spi_sck_i, spi_cs_n_i, spi_mosi_i;
  logic        spi_miso_o, spi_miso_en_o, busy_o;
  logic        tx_valid_i, tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o, rx_ready_i;
  logic [31:0] rx_data_o;
  logic        ovr_o, udr_o;

  int n_checks = 0;
  int n_errs   = 0;
  int ready_cnt = 0;
  logic ready_prev = 1'b0;
  logic ready_wide = 1'b0;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .cpol_i        (cpol_i),
    .cpha_i        (cpha_i),
    .lsb_i         (lsb_i),
    .dtb_i         (dtb_i),
    .clr_i         (clr_i),
    .spi_sck_i     (spi_sck_i),
    .spi_cs_n_i    (spi_cs_n_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_en_o (spi_miso_en_o),
    .busy_o        (busy_o),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .tx_data_i     (tx_data_i),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_data_o     (rx_data_o),
    .ovr_o         (ovr_o),
    .udr_o         (udr_o)
  );

  always #5 clk_i = ~clk_i;

  // tx_ready_o pulse counter and a flag for any pulse wider than one clk.
  always @(negedge clk_i) begin
    if (tx_ready_o) ready_cnt <= ready_cnt + 1;
    if (tx_ready_o && ready_prev) ready_wide <= 1'b1;
    ready_prev <= tx_ready_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk_i);
  endtask

  // SPI master: shifts nbits of mosi_w and collects miso in the same bit order.
  // Scrambles the config inputs once the slave has entered, to show they are captured.
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic lsb,
                          input logic [1:0] dtb, input int nbits, input logic [31:0] mosi_w,
                          output logic [31:0] miso_w, output int ready_before_last);
    int r0;
    int j;
    miso_w = '0;
    ready_before_last = 0;
    cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; dtb_i = dtb;
    spi_sck_i = cpol;
    half();
    r0 = ready_cnt;
    spi_cs_n_i = 1'b0;
    if (!cpha) spi_mosi_i = mosi_w[lsb ? 0 : nbits-1];
    half();
    cpol_i = ~cpol; cpha_i = ~cpha; lsb_i = ~lsb; dtb_i = ~dtb;
    for (int i = 0; i < nbits; i++) begin
      j = lsb ? i : nbits-1-i;
      if (!cpha) begin
        if (i == nbits-1) ready_before_last = ready_cnt - r0;
        spi_sck_i = ~spi_sck_i;
        miso_w[j] = spi_miso_o;
        half();
        spi_sck_i = ~spi_sck_i;
        if (i < nbits-1) spi_mosi_i = mosi_w[lsb ? i+1 : nbits-2-i];
        half();
      end else begin
        spi_sck_i = ~spi_sck_i;
        spi_mosi_i = mosi_w[j];
        half();
        if (i == nbits-1) ready_before_last = ready_cnt - r0;
        spi_sck_i = ~spi_sck_i;
        miso_w[j] = spi_miso_o;
        half();
      end
    end
    spi_cs_n_i = 1'b1;
    cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; dtb_i = dtb;
    half();
    half();
  endtask

  task automatic accept_rx();
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
  endtask

  logic [31:0] miso_w;
  int          rdy;

  initial begin
    rst_n_i = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00; clr_i = 1'b0;
    spi_sck_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
    tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("reset_ctrl", {25'b0, spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o,
                            ovr_o, udr_o}, 32'h0);
    check_eq("reset_rxdata", rx_data_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);

    // Mode 0, 8-bit, MSB first; the upper bits of tx_data_i must be ignored.
    tx_valid_i = 1'b1; tx_data_i = 32'hFFFF_FFA5;
    spi_xfer(1'b0, 1'b0, 1'b0, 2'b00, 8, 32'h3C, miso_w, rdy);
    check_eq("m0_miso", miso_w, 32'hA5);
    check_eq("m0_rx_valid", {31'b0, rx_valid_o}, 32'h1);
    check_eq("m0_rx_data", rx_data_o, 32'h3C);
    check_eq("m0_ready_pulses", rdy, 1);
    check_eq("m0_flags", {30'b0, ovr_o, udr_o}, 32'h0);
    check_eq("idle_pins", {29'b0, spi_miso_o, spi_miso_en_o, busy_o}, 32'h0);
    accept_rx();
    check_eq("m0_rx_valid_drop", {31'b0, rx_valid_o}, 32'h0);

    // Mode 3, 32-bit, LSB first.
    tx_data_i = 32'h1234_5678;
    spi_xfer(1'b1, 1'b1, 1'b1, 2'b11, 32, 32'hDEAD_BEEF, miso_w, rdy);
    check_eq("m3_miso", miso_w, 32'h1234_5678);
    check_eq("m3_rx_data", rx_data_o, 32'hDEAD_BEEF);
    check_eq("m3_ready_pulses", rdy, 1);
    accept_rx();

    // Mode 1, two back-to-back 16-bit words, rx_ready_i held low: second word is dropped.
    tx_data_i = 32'h0000_BEEF;
    spi_xfer(1'b0, 1'b1, 1'b0, 2'b01, 32, 32'h1234_ABCD, miso_w, rdy);
    check_eq("m1_miso", miso_w, 32'hBEEF_BEEF);
    check_eq("m1_rx_data", rx_data_o, 32'h0000_1234);
    check_eq("m1_rx_valid", {31'b0, rx_valid_o}, 32'h1);
    check_eq("m1_ovr", {31'b0, ovr_o}, 32'h1);
    check_eq("m1_udr", {31'b0, udr_o}, 32'h0);
    pulse_clr();
    check_eq("m1_ovr_clr", {31'b0, ovr_o}, 32'h0);
    accept_rx();

    // Underrun: tx_valid_i low for the whole transfer.
    tx_valid_i = 1'b0; tx_data_i = 32'hFFFF_FFFF;
    spi_xfer(1'b0, 1'b0, 1'b0, 2'b00, 8, 32'h81, miso_w, rdy);
    check_eq("udr_miso", miso_w, 32'h0);
    check_eq("udr_flag", {31'b0, udr_o}, 32'h1);
    check_eq("udr_rx_data", rx_data_o, 32'h81);
    pulse_clr();
    check_eq("udr_clr", {31'b0, udr_o}, 32'h0);
    accept_rx();

    // Abort after 5 of 8 bits, then a full transfer.
    tx_valid_i = 1'b1; tx_data_i = 32'hFF;
    spi_xfer(1'b0, 1'b0, 1'b0, 2'b00, 5, 32'h15, miso_w, rdy);
    check_eq("abort_rx_valid", {31'b0, rx_valid_o}, 32'h0);
    check_eq("abort_busy", {31'b0, busy_o}, 32'h0);
    tx_data_i = 32'hC3;
    spi_xfer(1'b0, 1'b0, 1'b0, 2'b00, 8, 32'h5A, miso_w, rdy);
    check_eq("after_abort_miso", miso_w, 32'hC3);
    check_eq("after_abort_rx", rx_data_o, 32'h5A);
    check_eq("after_abort_valid", {31'b0, rx_valid_o}, 32'h1);

    // Mode 2: reset asserted mid-word, with rx_valid and udr set.
    tx_valid_i = 1'b0;
    cpol_i = 1'b1; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00;
    spi_sck_i = 1'b1;
    half();
    spi_cs_n_i = 1'b0;
    half();
    check_eq("m2_busy_pre", {31'b0, busy_o}, 32'h1);
    check_eq("m2_udr_pre", {31'b0, udr_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      spi_sck_i = ~spi_sck_i;
      half();
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("m2_reset_ctrl", {25'b0, spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o,
                               ovr_o, udr_o}, 32'h0);
    check_eq("m2_reset_rxdata", rx_data_o, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spi_sck_i = ~spi_sck_i;
      half();
    end
    check_eq("m2_stay_idle", {30'b0, busy_o, udr_o}, 32'h0);
    spi_cs_n_i = 1'b1;
    half();
    tx_valid_i = 1'b1; tx_data_i = 32'h96;
    spi_xfer(1'b1, 1'b0, 1'b0, 2'b00, 8, 32'h69, miso_w, rdy);
    check_eq("m2_miso", miso_w, 32'h96);
    check_eq("m2_rx_data", rx_data_o, 32'h69);
    check_eq("m2_rx_valid", {31'b0, rx_valid_o}, 32'h1);

    check_eq("tx_ready_width", {31'b0, ready_wide}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on spi_sck_i, spi_cs_n_i and spi_mosi_i.
REQ-002 SHALL have port clk_i, input, 1, single system clock; all logic runs in this domain.
REQ-003 SHALL have port rst_n_i, input, 1, reset: asynchronous assert, active-low.
REQ-004 SHALL have port cpol_i, input, 1, SCK idle level.
REQ-005 SHALL have port cpha_i, input, 1, SCK phase.
REQ-006 SHALL have port lsb_i, input, 1, 1 = LSB first, 0 = MSB first.
REQ-007 SHALL have port dtb_i, input, 2, word length select: 00/01/10/11 = 8/16/24/32 bits.
REQ-008 SHALL have port clr_i, input, 1, clears the sticky flags.
REQ-009 SHALL have ports spi_sck_i, spi_cs_n_i and spi_mosi_i, each input, 1, asynchronous SPI pins.
REQ-010 SHALL have ports spi_miso_o and spi_miso_en_o, each output, 1: serial data out and its pad enable.
REQ-011 SHALL have port busy_o, output, 1, transaction active.
REQ-012 SHALL have ports tx_valid_i (input, 1), tx_ready_o (output, 1) and tx_data_i (input, 32): transmit word handshake.
REQ-013 SHALL have ports rx_valid_o (output, 1), rx_ready_i (input, 1) and rx_data_o (output, 32): receive word handshake.
REQ-014 SHALL have ports ovr_o and udr_o, each output, 1: sticky overrun and underrun flags.

Function
REQ-015 SHALL synchronize sck, cs_n and mosi through SYNC_STAGES flops, then detect edges with one further flop.
REQ-016 SHALL act on a pin edge SYNC_STAGES+1 clk after it occurs; the legal SCK half-period is at least SYNC_STAGES+3 clk.
REQ-017 SHALL implement FSM IDLE -> ACTIVE on a synchronized cs_n falling edge, and ACTIVE -> IDLE on a synchronized cs_n rising edge.
REQ-018 SHALL capture cpol_i, cpha_i, lsb_i and dtb_i on entry to ACTIVE; input changes during ACTIVE are ignored.
REQ-019 SHALL define the sample edge as SCK rising when cpol^cpha = 0, otherwise SCK falling; the shift edge is the opposite edge.
REQ-020 SHALL, on each sample edge in ACTIVE: shift mosi into the rx shift register and decrement the bit counter.
REQ-021 SHALL, on each shift edge in ACTIVE, advance the tx shift register only if the bit counter is below the word length; this covers both cpha cases.
REQ-022 SHALL drive spi_miso_o from tx register bit W-1 when MSB first, or bit 0 when LSB first, where W = 8*(dtb+1).
REQ-023 SHALL load words at each word-load point: ACTIVE entry, and the sample edge on which the counter reaches 0.
REQ-024 SHALL, at each word-load point, reload the counter to W and assert tx_ready_o for exactly 1 clk.
REQ-025 SHALL, if tx_valid_i is high in that cycle, load tx_data_i[W-1:0]; otherwise load zero and set udr_o.
REQ-026 SHALL, when the counter reaches 0, transfer the rx word right-justified to rx_data_o with upper bits 0, and assert rx_valid_o the next clk.
REQ-027 SHALL hold rx_valid_o and rx_data_o stable until rx_valid_o && rx_ready_i; rx_valid_o deasserts the clk after acceptance.
REQ-028 SHALL, if a word completes while rx_valid_o is high and not accepted that cycle, drop the new word and set ovr_o.
REQ-029 SHALL, on simultaneous word completion and acceptance, accept the old word and present the new one with rx_valid_o staying high.
REQ-030 SHALL, on cs_n rising mid-word, discard the partial word, pulse neither handshake, and go IDLE.
REQ-031 SHALL keep spi_miso_en_o = 1 and busy_o = 1 only in ACTIVE; spi_miso_o = 0 in IDLE.
REQ-032 SHALL keep ovr_o and udr_o sticky until clr_i; set-and-clear in the same clk leaves the flag set.
REQ-033 SHALL ignore sck edges while in IDLE.

Reset
REQ-034 SHALL, on rst_n_i low, immediately reset: FSM IDLE, counter 0, shift registers 0, synchronizers 1 for cs_n and cpol-independent 0 for sck/mosi.
REQ-035 SHALL, on rst_n_i low, immediately force all outputs 0 (spi_miso_o, spi_miso_en_o, busy_o, tx_ready_o, rx_valid_o, rx_data_o, ovr_o, udr_o).
REQ-036 SHALL, when reset is released mid-transaction, stay IDLE until the next cs_n falling edge.

Verification
REQ-037 Mode 0, 8-bit, MSB first: tx 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data_o = 0x3C; exactly one tx_ready_o pulse.
REQ-038 Mode 3, 32-bit, LSB first: tx 0x12345678, master sends 0xDEADBEEF -> master reads 0x12345678; rx_data_o = 0xDEADBEEF.
REQ-039 Mode 1, two back-to-back 16-bit words with rx_ready_i held low -> first word held, ovr_o = 1, second word dropped.
REQ-040 tx_valid_i low at cs_n fall -> miso all zeros, udr_o = 1; clr_i -> udr_o = 0.
REQ-041 cs_n rises after 5 of 8 bits -> no rx_valid_o; next full transfer receives correctly.
REQ-042 rst_n_i asserted mid-word in mode 2 -> all outputs 0 immediately; next transaction correct.
